// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word type, RAM handshake state, arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Status reported by the RAM for the access currently presented to it
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter ownership of the RAM port
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arbstate_t;

  // 16-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Grant watchdog: counts cycles while enabled, flags expiry on the
// TIMEOUT-th enabled cycle since the last clear.
module mem_arb_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count_q, count_d;

  // Expiry is raised during the last allowed grant cycle so the abort
  // lands on the same edge at which the count would reach TIMEOUT.
  assign expire = enable && (count_q == CW'(TIMEOUT - 1));

  // Next count: clear wins, otherwise advance while enabled and not expired
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expire) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter in front of a single RAM port. Data requests win.
// Request is latched on grant entry; RAM port is driven only from latches.
// Optional build macro MEM_ARBITER_STATS_EN adds icount/dcount completion
// counters (16-bit, saturating).
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
`ifdef MEM_ARBITER_STATS_EN
  output logic [15:0] icount,
  output logic [15:0] dcount,
`endif
  output logic      err
);

  arbstate_t state_q, state_d;
  word_t     addr_q, addr_d;
  word_t     store_q, store_d;
  logic      wen_q, wen_d;
  logic      err_q, err_d;
  logic      i_done, d_done;
  logic      dreq;
  logic      in_grant;
  logic      timer_expire;

  assign dreq     = dREN | dWEN;
  assign in_grant = (state_q != IDLE);

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear  (!in_grant),
    .enable (in_grant),
    .expire (timer_expire)
  );

  // Arbitration, latching on grant entry, and grant termination
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wen_d   = wen_q;
    err_d   = err_q;
    i_done  = 1'b0;
    d_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq) begin
          state_d = DGRANT;
          addr_d  = daddr;
          store_d = dstore;
          wen_d   = dWEN;          // dREN+dWEN together is taken as a write
        end else if (iREN) begin
          state_d = IGRANT;
          addr_d  = iaddr;
          wen_d   = 1'b0;
        end
      end
      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;          // requester gave up: abandon quietly
        end else if (ramstate == ACCESS) begin
          i_done  = 1'b1;
          state_d = IDLE;
        end else if (ramstate == ERROR || timer_expire) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DGRANT: begin
        if (!dreq) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          d_done  = 1'b1;
          state_d = IDLE;
        end else if (ramstate == ERROR || timer_expire) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, request latches and sticky error
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
    end
  end

  // RAM port comes only from latched values; enables only while granted
  assign ramREN   = in_grant && !wen_q;
  assign ramWEN   = in_grant &&  wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  // Waits follow the raw requests but are forced low while reset is held
  assign iwait = nRST && iREN && !i_done;
  assign dwait = nRST && dreq && !d_done;
  assign iload = i_done ? ramload : 32'h0;
  assign dload = d_done ? ramload : 32'h0;
  assign err   = err_q;

`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] icount_q, icount_d, dcount_q, dcount_d;

  // Completion counters, saturating
  always_comb begin
    icount_d = i_done ? sat_inc16(icount_q) : icount_q;
    dcount_d = d_done ? sat_inc16(dcount_q) : dcount_q;
  end

  // Counter registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount_q <= '0;
      dcount_q <= '0;
    end else begin
      icount_q <= icount_d;
      dcount_q <= dcount_d;
    end
  end

  assign icount = icount_q;
  assign dcount = dcount_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-modelled RAM and a
// scoreboard of expected completions per requester.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LAT = 1;
  localparam int TO  = 15;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, iwait;
  word_t     iaddr, iload;
  logic      dREN, dWEN, dwait;
  word_t     daddr, dstore, dload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  logic      err;
`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] icount, dcount;
`endif

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
`ifdef MEM_ARBITER_STATS_EN
    .icount   (icount),
    .dcount   (dcount),
`endif
    .err      (err)
  );

  // RAM model: ACCESS after LAT busy cycles of a steady request
  word_t mem [0:255];
  int    lat_cnt;
  bit    stall, rerr;

  always_comb begin
    if (!(ramREN || ramWEN))  ramstate = FREE;
    else if (rerr)            ramstate = ERROR;
    else if (stall)           ramstate = BUSY;
    else if (lat_cnt >= LAT)  ramstate = ACCESS;
    else                      ramstate = BUSY;
  end

  assign ramload = mem[ramaddr[9:2]];

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lat_cnt  <= 0;
      mem[16]  <= 32'h2402000A;   // 0x40
      mem[64]  <= 32'h11112222;   // 0x100
    end else if (ramREN || ramWEN) begin
      lat_cnt <= (ramstate == ACCESS) ? 0 : lat_cnt + 1;
      if (ramWEN && ramstate == ACCESS) mem[ramaddr[9:2]] <= ramstore;
    end else begin
      lat_cnt <= 0;
    end
  end

  // Scoreboard
  typedef struct {
    logic  is_wr;
    word_t data;
  } dexp_t;

  word_t i_exp[$];
  dexp_t d_exp[$];
  int    checks = 0;
  int    errors = 0;
  bit    i_seen, d_seen;
  int    ni = 0;
  int    nd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock, then sample and retire any completion this cycle
  task automatic cyc();
    @(posedge CLK);
    #1;
    if (nRST && iREN && !iwait) begin
      i_seen = 1;
      ni++;
      if (i_exp.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL i_unexpected: observed completion at %h expected none", ramaddr);
      end else begin
        word_t e;
        e = i_exp.pop_front();
        $display("I read  addr=%h data=%h", ramaddr, iload);
        chk("iload", iload, e);
      end
    end
    if (nRST && (dREN || dWEN) && !dwait) begin
      d_seen = 1;
      nd++;
      if (d_exp.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL d_unexpected: observed completion at %h expected none", ramaddr);
      end else begin
        dexp_t e;
        e = d_exp.pop_front();
        if (e.is_wr) begin
          $display("D write addr=%h data=%h", ramaddr, ramstore);
          chk("d_write_en", 32'(ramWEN), 32'd1);
        end else begin
          $display("D read  addr=%h data=%h", ramaddr, dload);
          chk("dload", dload, e.data);
        end
      end
    end
  endtask

  task automatic wait_done(input bit is_d, input string tag);
    bit seen;
    i_seen = 0;
    d_seen = 0;
    seen   = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc();
      seen = is_d ? d_seen : i_seen;
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL %s: observed no completion in 20 cycles, expected completion", tag);
    end
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b1; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; stall = 0; rerr = 0;

    // Reset state, with a request held to show waits are suppressed
    repeat (2) cyc();
    chk("rst_iwait",   32'(iwait),  32'd0);
    chk("rst_ramren",  32'(ramREN), 32'd0);
    chk("rst_ramwen",  32'(ramWEN), 32'd0);
    chk("rst_err",     32'(err),    32'd0);
    chk("rst_ramaddr", ramaddr,     32'h0);
    chk("rst_iload",   iload,       32'h0);
    iREN = 1'b0;
    nRST = 1'b1;
    cyc();

    // Single instruction fetch
    iaddr = 32'h40; iREN = 1'b1; i_exp.push_back(32'h2402000A);
    #1;
    chk("t1_iwait_req", 32'(iwait), 32'd1);
    cyc();
    chk("t1_ramren",  32'(ramREN), 32'd1);
    chk("t1_ramaddr", ramaddr,     32'h40);
    chk("t1_iwait",   32'(iwait),  32'd1);
    wait_done(0, "t1_done");
    iREN = 1'b0;
    cyc();
    chk("t1_iload_clr", iload,       32'h0);
    chk("t1_idle",      32'(ramREN), 32'd0);

    // Simultaneous requests: data first, one idle cycle, then instruction
    iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h100;
    d_exp.push_back('{1'b0, 32'h11112222});
    i_exp.push_back(32'h2402000A);
    cyc();
    chk("t2_dgrant_addr", ramaddr,    32'h100);
    chk("t2_iwait",       32'(iwait), 32'd1);
    chk("t2_dwait",       32'(dwait), 32'd1);
    d_seen = 0;
    cyc();
    chk("t2_dfirst",     32'(d_seen), 32'd1);
    chk("t2_iwait_hold", 32'(iwait),  32'd1);
    dREN = 1'b0;
    cyc();
    chk("t2_gap_ramren", 32'(ramREN), 32'd0);
    chk("t2_gap_iwait",  32'(iwait),  32'd1);
    cyc();
    chk("t2_igrant_addr", ramaddr,     32'h40);
    chk("t2_igrant_ren",  32'(ramREN), 32'd1);
    wait_done(0, "t2_idone");
    iREN = 1'b0;
    cyc();

    // Write then read back
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    d_exp.push_back('{1'b1, 32'h0});
    cyc();
    chk("t3_ramwen",   32'(ramWEN), 32'd1);
    chk("t3_ramstore", ramstore,    32'hDEADBEEF);
    wait_done(1, "t3_wdone");
    dWEN = 1'b0;
    cyc();
    dREN = 1'b1; daddr = 32'h200;
    d_exp.push_back('{1'b0, 32'hDEADBEEF});
    wait_done(1, "t3_rdone");
    dREN = 1'b0;
    cyc();

    // Request dropped one cycle into the grant
    dREN = 1'b1; daddr = 32'h100;
    cyc();
    chk("t4_ramren", 32'(ramREN), 32'd1);
    dREN = 1'b0;
    #1;
    chk("t4_dwait", 32'(dwait), 32'd0);
    chk("t4_dload", dload,      32'h0);
    cyc();
    chk("t4_idle",    32'(ramREN), 32'd0);
    chk("t4_dload2",  dload,       32'h0);
    chk("t4_err",     32'(err),    32'd0);

    // Address change mid-grant is ignored
    dREN = 1'b1; daddr = 32'h40;
    d_exp.push_back('{1'b0, 32'h2402000A});
    cyc();
    daddr = 32'h100;
    #1;
    chk("t5_latched", ramaddr, 32'h40);
    wait_done(1, "t5_done");
    dREN = 1'b0;
    cyc();

    // RAM error aborts and sets sticky err
    rerr = 1; iREN = 1'b1; iaddr = 32'h40;
    cyc();
    chk("t6_iwait",   32'(iwait), 32'd1);
    chk("t6_err_pre", 32'(err),   32'd0);
    cyc();
    chk("t6_err",  32'(err),    32'd1);
    chk("t6_idle", 32'(ramREN), 32'd0);
    iREN = 1'b0; rerr = 0;
    cyc();
    chk("t6_sticky", 32'(err), 32'd1);
    nRST = 1'b0;
    cyc();
    chk("rst2_err", 32'(err), 32'd0);
    nRST = 1'b1;
    cyc();

    // Watchdog: TO grant cycles of BUSY, then abort
    stall = 1; dREN = 1'b1; daddr = 32'h100;
    for (int k = 1; k <= TO; k++) begin
      cyc();
      chk("t7_dwait",  32'(dwait),  32'd1);
      chk("t7_ramren", 32'(ramREN), 32'd1);
      chk("t7_noerr",  32'(err),    32'd0);
    end
    cyc();
    chk("t7_err",  32'(err),    32'd1);
    chk("t7_idle", 32'(ramREN), 32'd0);
    dREN = 1'b0;
    repeat (3) cyc();
    chk("t7_sticky", 32'(err), 32'd1);

`ifdef MEM_ARBITER_STATS_EN
    chk("stats_icount", 32'(icount), 32'(ni));
    chk("stats_dcount", 32'(dcount), 32'(nd));
`endif

    // Reset asserted mid-grant
    dREN = 1'b1; daddr = 32'h100;
    cyc();
    chk("t8_grant", 32'(ramREN), 32'd1);
    nRST = 1'b0;
    #1;
    chk("t8_ramren", 32'(ramREN), 32'd0);
    chk("t8_ramwen", 32'(ramWEN), 32'd0);
    chk("t8_dwait",  32'(dwait),  32'd0);
    chk("t8_dload",  dload,       32'h0);
    chk("t8_err",    32'(err),    32'd0);
`ifdef MEM_ARBITER_STATS_EN
    chk("t8_dcount", 32'(dcount), 32'd0);
    chk("t8_icount", 32'(icount), 32'd0);
`endif
    cyc();
    dREN = 1'b0; stall = 0; nRST = 1'b1;
    cyc();

    chk("i_exp_left", 32'(i_exp.size()), 32'd0);
    chk("d_exp_left", 32'(d_exp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
